// File: rtl/signal_out_generator_module.sv
// Square-wave generator with programmable high/low phase lengths.
// Configuration is handshaked into a pending register and only applied
// on a period boundary (entry to HIGH), or the cycle after acceptance
// when idle, so the output never carries a truncated or mixed period.
// Optional feature macro: GEN_BURST_EN (finite pulse bursts with burst_done).
module signal_out_generator_module #(
  parameter int CNT_W = 24
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic [15:0]      burst_len,
  output logic             signal_out,
  output logic             edge_pulse,
  output logic             busy,
  output logic             burst_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // A zero phase length would stall the counter; treat it as one cycle.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] v);
    clamp_len = (v == '0) ? CNT_W'(1) : v;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_high_q, act_high_d, act_low_q, act_low_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d, pend_low_q, pend_low_d;
  logic             pend_vld_q, pend_vld_d;
  logic             cfg_ready_q, so_q, ep_q, busy_q, done_q, done_d;
  logic             accept_s, hi_entry_s, apply_s, start_s, last_s;
  logic [CNT_W-1:0] eff_high_s;

`ifdef GEN_BURST_EN
  logic [15:0] act_burst_q, act_burst_d, pend_burst_q, pend_burst_d;
  logic [15:0] pulses_q, pulses_d, eff_burst_s;
  logic        armed_q, armed_d;

  // A new burst may only start once enable has been seen low after the last one.
  assign start_s = enable && armed_q;
  assign last_s  = (pulses_q == 16'd1);
`else
  logic unused_burst_s;

  assign unused_burst_s = ^burst_len;
  assign start_s        = enable;
  assign last_s         = 1'b0;
`endif

  assign accept_s = cfg_valid && cfg_ready_q;

  // Next-state, phase counter and configuration bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_high_d  = act_high_q;
    act_low_d   = act_low_q;
    pend_high_d = pend_high_q;
    pend_low_d  = pend_low_q;
    pend_vld_d  = pend_vld_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_s) state_d = HIGH;
        else         state_d = IDLE;
      end
      HIGH: begin
        if (cnt_q == '0) state_d = LOW;
        else             state_d = HIGH;
      end
      LOW: begin
        if (cnt_q == '0) begin
          if (enable && !last_s) state_d = HIGH;
          else                   state_d = IDLE;
        end else begin
          state_d = LOW;
        end
      end
      default: state_d = IDLE;
    endcase

    hi_entry_s = (state_d == HIGH) && (state_q != HIGH);
    apply_s    = pend_vld_q && ((state_q == IDLE) || hi_entry_s);
    eff_high_s = apply_s ? pend_high_q : act_high_q;

    // Phase lengths are stored clamped to >= 1, so length-1 never wraps.
    if (hi_entry_s) begin
      cnt_d = eff_high_s - CNT_W'(1);
    end else if ((state_q == HIGH) && (cnt_q == '0)) begin
      cnt_d = act_low_q - CNT_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // cfg_ready mirrors !pend_vld_q, so accept and apply never coincide.
    if (apply_s) begin
      act_high_d = pend_high_q;
      act_low_d  = pend_low_q;
      pend_vld_d = 1'b0;
    end else if (accept_s) begin
      pend_high_d = clamp_len(cfg_high);
      pend_low_d  = clamp_len(cfg_low);
      pend_vld_d  = 1'b1;
    end else begin
      pend_vld_d = pend_vld_q;
    end

`ifdef GEN_BURST_EN
    act_burst_d  = act_burst_q;
    pend_burst_d = pend_burst_q;
    armed_d      = armed_q;
    eff_burst_s  = apply_s ? pend_burst_q : act_burst_q;

    if (apply_s) begin
      act_burst_d = pend_burst_q;
    end else if (accept_s) begin
      pend_burst_d = (burst_len == 16'd0) ? 16'd1 : burst_len;
    end else begin
      pend_burst_d = pend_burst_q;
    end

    if ((state_q == IDLE) && hi_entry_s) begin
      pulses_d = (eff_burst_s == 16'd0) ? 16'd1 : eff_burst_s;
    end else if ((state_q == LOW) && (cnt_q == '0) && (pulses_q != 16'd0)) begin
      pulses_d = pulses_q - 16'd1;
    end else begin
      pulses_d = pulses_q;
    end

    done_d = (state_q == LOW) && (cnt_q == '0) && last_s;

    if (!enable)     armed_d = 1'b1;
    else if (done_d) armed_d = 1'b0;
    else             armed_d = armed_q;
`endif
  end

  // State, counters, configuration and registered outputs.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      act_high_q  <= CNT_W'(1);
      act_low_q   <= CNT_W'(1);
      pend_high_q <= '0;
      pend_low_q  <= '0;
      pend_vld_q  <= 1'b0;
      cfg_ready_q <= 1'b1;
      so_q        <= 1'b0;
      ep_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_high_q  <= act_high_d;
      act_low_q   <= act_low_d;
      pend_high_q <= pend_high_d;
      pend_low_q  <= pend_low_d;
      pend_vld_q  <= pend_vld_d;
      cfg_ready_q <= !pend_vld_d;
      so_q        <= (state_d == HIGH);
      ep_q        <= hi_entry_s;
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
    end
  end

`ifdef GEN_BURST_EN
  // Burst length bookkeeping and re-arm tracking.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      act_burst_q  <= 16'd1;
      pend_burst_q <= 16'd0;
      pulses_q     <= 16'd0;
      armed_q      <= 1'b1;
    end else begin
      act_burst_q  <= act_burst_d;
      pend_burst_q <= pend_burst_d;
      pulses_q     <= pulses_d;
      armed_q      <= armed_d;
    end
  end
`endif

  assign cfg_ready  = cfg_ready_q;
  assign signal_out = so_q;
  assign edge_pulse = ep_q;
  assign busy       = busy_q;
`ifdef GEN_BURST_EN
  assign burst_done = done_q;
`else
  assign burst_done = 1'b0;
`endif

endmodule

// File: tb/tb_signal_out_generator_module.sv
// Scoreboard bench for signal_out_generator_module: each scenario pushes
// the expected per-cycle waveform, then drains it against the DUT.
module tb_signal_out_generator_module;

  logic        clk_50M = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_high;
  logic [23:0] cfg_low;
  logic [15:0] burst_len;
  logic        signal_out;
  logic        edge_pulse;
  logic        busy;
  logic        burst_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic so;
    logic ep;
    logic bsy;
    logic done;
  } exp_t;

  exp_t sb_q[$];

  signal_out_generator_module #(.CNT_W(24)) dut (
    .clk_50M   (clk_50M),
    .rst       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_high  (cfg_high),
    .cfg_low   (cfg_low),
    .burst_len (burst_len),
    .signal_out(signal_out),
    .edge_pulse(edge_pulse),
    .busy      (busy),
    .burst_done(burst_done)
  );

  // 50 MHz clock.
  always #10 clk_50M = ~clk_50M;

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic push_period(input int h, input int l);
    for (int i = 0; i < h; i++) sb_q.push_back('{so: 1'b1, ep: (i == 0), bsy: 1'b1, done: 1'b0});
    for (int i = 0; i < l; i++) sb_q.push_back('{so: 1'b0, ep: 1'b0, bsy: 1'b1, done: 1'b0});
  endtask

  task automatic push_idle(input int n, input bit done_first);
    for (int i = 0; i < n; i++) sb_q.push_back('{so: 1'b0, ep: 1'b0, bsy: 1'b0, done: done_first && (i == 0)});
  endtask

  // Advance n cycles, popping one expected entry per cycle.
  task automatic drain(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s underflow at cycle %0d", tag, i);
      end else begin
        e = sb_q.pop_front();
        if ({signal_out, edge_pulse, busy, burst_done} !== {e.so, e.ep, e.bsy, e.done}) begin
          errors++;
          $display("FAIL %s cycle %0d so/ep/busy/done got %b%b%b%b expected %b%b%b%b",
                   tag, i, signal_out, edge_pulse, busy, burst_done, e.so, e.ep, e.bsy, e.done);
        end
      end
    end
  endtask

  task automatic check_ready(input string tag, input logic exp);
    checks++;
    if (cfg_ready !== exp) begin
      errors++;
      $display("FAIL %s cfg_ready got %b expected %b", tag, cfg_ready, exp);
    end
  endtask

  // Offer one configuration in IDLE and let it apply.
  task automatic load_cfg(input string tag, input int h, input int l, input int b);
    cfg_valid = 1'b1;
    cfg_high  = 24'(h);
    cfg_low   = 24'(l);
    burst_len = 16'(b);
    push_idle(2, 1'b0);
    drain(tag, 1);
    check_ready({tag, "_pending"}, 1'b0);
    cfg_valid = 1'b0;
    drain(tag, 1);
    check_ready({tag, "_applied"}, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_high = 24'd0; cfg_low = 24'd0; burst_len = 16'd0;
    repeat (3) tick();
    checks++;
    if ({signal_out, edge_pulse, busy, burst_done, cfg_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset so/ep/busy/done/rdy got %b%b%b%b%b expected 00001",
               signal_out, edge_pulse, busy, burst_done, cfg_ready);
    end
    rst = 1'b0;
    push_idle(2, 1'b0);
    drain("post_reset", 2);
  endtask

  task automatic test_default_toggle();
    enable = 1'b1;
    for (int p = 0; p < 4; p++) push_period(1, 1);
    drain("default_toggle", 8);
    enable = 1'b0;
    push_idle(2, 1'b0);
    drain("default_stop", 2);
  endtask

  task automatic test_cfg_period();
    load_cfg("cfg_3_7", 3, 7, 0);
    enable = 1'b1;
    for (int p = 0; p < 5; p++) push_period(3, 7);
    drain("period_3_7", 50);
  endtask

  task automatic test_cfg_update();
    push_period(3, 7);
    drain("upd_first", 1);
    check_ready("upd_before", 1'b1);
    cfg_valid = 1'b1; cfg_high = 24'd5; cfg_low = 24'd5;
    drain("upd_accept", 1);
    check_ready("upd_blocked", 1'b0);
    cfg_valid = 1'b0;
    drain("upd_old_period", 8);
    check_ready("upd_still_blocked", 1'b0);
    push_period(5, 5);
    drain("upd_new_entry", 1);
    check_ready("upd_boundary", 1'b1);
    enable = 1'b0;
    push_idle(2, 1'b0);
    drain("upd_new_period", 11);
  endtask

  task automatic test_enable_drop();
    load_cfg("cfg_4_4", 4, 4, 0);
    enable = 1'b1;
    push_period(4, 4);
    push_idle(3, 1'b0);
    drain("drop_first", 1);
    enable = 1'b0;
    drain("drop_complete", 10);
  endtask

  task automatic test_clamp_rst();
    load_cfg("cfg_0_0", 0, 0, 0);
    enable = 1'b1;
    for (int p = 0; p < 3; p++) push_period(1, 1);
    sb_q.push_back('{so: 1'b1, ep: 1'b1, bsy: 1'b1, done: 1'b0});
    drain("clamp_1_1", 7);
    rst = 1'b1;
    #1;
    checks++;
    if ({signal_out, busy} !== 2'b00) begin
      errors++;
      $display("FAIL async_rst so/busy got %b%b expected 00", signal_out, busy);
    end
    enable = 1'b0;
    #2;
    rst = 1'b0;
    push_idle(3, 1'b0);
    drain("rst_hold_low", 3);
    enable = 1'b1;
    push_period(1, 1);
    push_period(1, 1);
    drain("rst_restart", 4);
    enable = 1'b0;
    push_idle(2, 1'b0);
    drain("rst_stop", 2);
  endtask

  task automatic test_burst_ignored();
    load_cfg("cfg_2_2_b2", 2, 2, 2);
    enable = 1'b1;
    for (int p = 0; p < 4; p++) push_period(2, 2);
    drain("continuous_2_2", 16);
    enable = 1'b0;
    push_idle(2, 1'b0);
    drain("continuous_stop", 2);
  endtask

  task automatic test_burst();
    load_cfg("cfg_burst", 2, 2, 4);
    enable = 1'b1;
    for (int p = 0; p < 4; p++) push_period(2, 2);
    push_idle(6, 1'b1);
    drain("burst_1", 22);
    enable = 1'b0;
    push_idle(1, 1'b0);
    drain("burst_rearm", 1);
    enable = 1'b1;
    for (int p = 0; p < 4; p++) push_period(2, 2);
    push_idle(2, 1'b1);
    drain("burst_2", 18);
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef GEN_BURST_EN
    test_burst();
`else
    test_default_toggle();
    test_cfg_period();
    test_cfg_update();
    test_enable_drop();
    test_clamp_rst();
    test_burst_ignored();
`endif
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover entries %0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
